// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  typedef enum logic [2:0] {
    REQ  = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    WAIT = 3'd4
  } ifu_state_e;

  localparam logic [1:0]  FC_NONE     = 2'd0;
  localparam logic [1:0]  FC_MISALIGN = 2'd1;
  localparam logic [1:0]  FC_BUSERR   = 2'd2;
  localparam logic [1:0]  FC_TIMEOUT  = 2'd3;

  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

endpackage

// File: rtl/ifu_fetch_timeout_cnt.sv
// rtl/ifu_fetch_timeout_cnt.sv - R-phase wait counter with expiry flag
module ifu_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Expired on the TIMEOUT-th enabled cycle, i.e. when the count would reach TIMEOUT
  always_comb begin
    expired = enable && (cnt_q == W'(TIMEOUT - 1));
  end

  // Clear dominates; count enabled cycles and stop once expired
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC, AR/R read, fault detection
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update,
  input  logic [31:0] pc_next,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        IFU_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        misaligned;
  logic        tmo_expired;

  assign misaligned = (pc_q[1:0] != 2'b00);

  ifu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ADDR),
    .enable  (state_q == DATA),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= REQ;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ:  state_d = misaligned ? DONE : ADDR;
      ADDR: if (arready) state_d = DATA;
      DATA: if (rvalid || tmo_expired) state_d = DONE;
      DONE: state_d = WAIT;
      WAIT: if (pc_update || pending_q) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  // Bus handshakes and done pulse are decoded from the state, so reset drops them at once
  always_comb begin
    arvalid  = (state_q == ADDR);
    rready   = (state_q == DATA);
    IFU_done = (state_q == DONE);
  end

  // Datapath: PC, held instruction, fault status and the early-strobe pending slot
  always_comb begin
    pc_d         = pc_q;
    insn_d       = insn_q;
    fault_d      = fault_q;
    cause_d      = cause_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    if (pc_update && (state_q != WAIT)) begin
      pending_d    = 1'b1;
      pending_pc_d = pc_next;
    end
    unique case (state_q)
      REQ: begin
        if (misaligned) begin
          insn_d  = NOP_INSN;
          fault_d = 1'b1;
          cause_d = FC_MISALIGN;
        end
      end
      DATA: begin
        if (rvalid) begin
          if (rresp == RESP_OKAY) begin
            insn_d = rdata;
          end else begin
            insn_d  = NOP_INSN;
            fault_d = 1'b1;
            cause_d = FC_BUSERR;
          end
        end else if (tmo_expired) begin
          insn_d  = NOP_INSN;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end
      end
      WAIT: begin
        // A live strobe takes priority over one captured earlier
        if (pc_update || pending_q) begin
          pc_d      = pc_update ? pc_next : pending_pc_q;
          fault_d   = 1'b0;
          cause_d   = FC_NONE;
          pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      insn_q       <= NOP_INSN;
      fault_q      <= 1'b0;
      cause_q      <= FC_NONE;
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
    end else begin
      pc_q         <= pc_d;
      insn_q       <= insn_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  assign araddr      = pc_q;
  assign pc          = pc_q;
  assign instruction = insn_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_update;
  logic [31:0] pc_next;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        IFU_done;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;

  int          cyc, arv, rr;
  logic [31:0] a0;
  bit          st;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_update   (pc_update),
    .pc_next     (pc_next),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .pc          (pc),
    .instruction (instruction),
    .IFU_done    (IFU_done),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_update(input logic [31:0] a);
    pc_update = 1'b1;
    pc_next   = a;
    step();
    pc_update = 1'b0;
  endtask

  // Memory responder: stalls arready/rvalid a given number of cycles, optionally
  // pulses pc_update at a chosen cycle, and stops on IFU_done.
  task automatic do_fetch(input int ar_stall, input int r_stall, input logic [31:0] data,
                          input logic [1:0] resp, input int upd_at, input logic [31:0] upd_pc,
                          output int n_cyc, output int n_arv, output int n_rr,
                          output logic [31:0] first_addr, output bit addr_stable);
    n_cyc = 0; n_arv = 0; n_rr = 0; first_addr = '0; addr_stable = 1'b1;
    while (!IFU_done && n_cyc < 64) begin
      if (arvalid) begin
        n_arv++;
        if (n_arv == 1) first_addr = araddr;
        else if (araddr !== first_addr) addr_stable = 1'b0;
      end
      if (rready) n_rr++;
      arready   = arvalid && (n_arv > ar_stall);
      rvalid    = rready && (n_rr > r_stall);
      rdata     = data;
      rresp     = resp;
      pc_update = (n_cyc == upd_at);
      pc_next   = upd_pc;
      step();
      n_cyc++;
    end
    arready   = 1'b0;
    rvalid    = 1'b0;
    pc_update = 1'b0;
    check("done_seen", IFU_done, 1);
  endtask

  initial begin
    rst = 1'b1; pc_update = 1'b0; pc_next = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_araddr", araddr, 32'h8000_0000);
    check("rst_insn", instruction, 32'h0000_0013);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_done", IFU_done, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_cause", fault_cause, 0);

    // First fetch, no stalls
    rst = 1'b0;
    do_fetch(0, 0, 32'h0010_0093, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t1_latency", cyc, 3);
    check("t1_araddr", a0, 32'h8000_0000);
    check("t1_arv_cycles", arv, 1);
    check("t1_insn", instruction, 32'h0010_0093);
    check("t1_pc", pc, 32'h8000_0000);
    check("t1_fault", fetch_fault, 0);
    step();
    check("t1_done_pulse", IFU_done, 0);

    // Stalled fetch
    pulse_update(32'h8000_0004);
    do_fetch(3, 2, 32'h0020_0113, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t2_arv_cycles", arv, 4);
    check("t2_addr_stable", st, 1);
    check("t2_araddr", a0, 32'h8000_0004);
    check("t2_rr_cycles", rr, 3);
    check("t2_insn", instruction, 32'h0020_0113);
    check("t2_pc", pc, 32'h8000_0004);
    check("t2_fault", fetch_fault, 0);
    step();
    check("t2_done_pulse", IFU_done, 0);

    // Misaligned PC
    pulse_update(32'h8000_0006);
    do_fetch(0, 0, 32'hffff_ffff, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t3_no_arvalid", arv, 0);
    check("t3_latency", cyc, 1);
    check("t3_fault", fetch_fault, 1);
    check("t3_cause", fault_cause, 1);
    check("t3_insn", instruction, 32'h0000_0013);
    check("t3_pc", pc, 32'h8000_0006);
    step();
    check("t3_done_pulse", IFU_done, 0);
    check("t3_fault_held", fetch_fault, 1);

    // Bus error, best-case latency (strobe to done = 4)
    pulse_update(32'h8000_0008);
    check("t4_fault_clr", fetch_fault, 0);
    check("t4_cause_clr", fault_cause, 0);
    do_fetch(0, 0, 32'hdead_beef, 2'b10, -1, '0, cyc, arv, rr, a0, st);
    check("t4_latency", cyc, 3);
    check("t4_fault", fetch_fault, 1);
    check("t4_cause", fault_cause, 2);
    check("t4_insn", instruction, 32'h0000_0013);
    step();

    // Timeout after 8 DATA cycles
    pulse_update(32'h8000_000c);
    do_fetch(0, 100, 32'h1234_5678, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t5_rr_cycles", rr, 8);
    check("t5_latency", cyc, 10);
    check("t5_rready_drop", rready, 0);
    check("t5_fault", fetch_fault, 1);
    check("t5_cause", fault_cause, 3);
    check("t5_insn", instruction, 32'h0000_0013);
    step();

    // Early strobe during DATA, refetch with no strobe in WAIT
    pulse_update(32'h8000_0020);
    do_fetch(0, 2, 32'h0030_0193, 2'b00, 3, 32'h8000_0010, cyc, arv, rr, a0, st);
    check("t6_pc", pc, 32'h8000_0020);
    check("t6_insn", instruction, 32'h0030_0193);
    check("t6_fault", fetch_fault, 0);
    step();
    check("t6_wait_pc", pc, 32'h8000_0020);
    check("t6_done_pulse", IFU_done, 0);
    do_fetch(0, 0, 32'h0040_0213, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t6_refetch_lat", cyc, 4);
    check("t6_refetch_addr", a0, 32'h8000_0010);
    check("t6_refetch_pc", pc, 32'h8000_0010);
    check("t6_refetch_insn", instruction, 32'h0040_0213);
    step();

    // Reset during the address phase, then stray rvalid
    pulse_update(32'h8000_0030);
    step();
    check("t7_arvalid_pre", arvalid, 1);
    rst = 1'b1;
    #1;
    check("t7_arvalid_async", arvalid, 0);
    check("t7_rready_async", rready, 0);
    check("t7_pc_rst", pc, 32'h8000_0000);
    rvalid = 1'b1; rdata = 32'hbadb_adba; rresp = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t7_stray_rready", rready, 0);
    @(negedge clk);
    step();
    check("t7_addr_rready", rready, 0);
    check("t7_arvalid", arvalid, 1);
    check("t7_araddr", araddr, 32'h8000_0000);
    rvalid = 1'b0;
    do_fetch(0, 0, 32'h0050_0293, 2'b00, -1, '0, cyc, arv, rr, a0, st);
    check("t7_latency", cyc, 2);
    check("t7_insn", instruction, 32'h0050_0293);
    check("t7_pc", pc, 32'h8000_0000);
    check("t7_fault", fetch_fault, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage, directly upstream of the decode stage. It owns the PC and issues one read per instruction on an AXI4-Lite-style read channel (AR/R) to instruction memory. It latches the returned word and presents it with a one-cycle IFU_done pulse. It then waits for the write-back/PC-update strobe before fetching again, with misalignment, bus-error and timeout detection.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address
TIMEOUT, 255, max cycles waiting in R phase before fault (counter width = $clog2(TIMEOUT+1))

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
pc_update  input  1  strobe: downstream retired current instr, load pc_next
pc_next  input  32  next PC from execute/write-back
araddr  output  32  fetch address
arvalid  output  1  address valid
arready  input  1  memory accepts address
rdata  input  32  instruction word
rresp  input  2  response; nonzero = error
rvalid  input  1  data valid
rready  output  1  IFU accepts data
pc  output  32  PC of the held instruction
instruction  output  32  held instruction word
IFU_done  output  1  one-cycle pulse: instruction valid for decode
fetch_fault  output  1  level: fault on current fetch, held until next pc_update
fault_cause  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout

Behaviour:
- Reset (async, immediate): pc=RESET_PC, instruction=32'h0000_0013 (nop), arvalid=0, rready=0, IFU_done=0, fetch_fault=0, fault_cause=0, timeout counter=0, pending=0, state=REQ.
- araddr is always driven equal to pc.
- States: REQ, ADDR, DATA, DONE, WAIT.
- REQ: if pc[1:0]!=0, set fetch_fault=1, fault_cause=1, go DONE with no bus access. Otherwise go ADDR with arvalid=1.
- ADDR: hold arvalid=1 and araddr stable until arready. On arready, next cycle arvalid=0, rready=1, counter cleared, go DATA.
- DATA: rready=1; counter increments each cycle.
  - rvalid with rresp==0: latch instruction=rdata, go DONE.
  - rvalid with rresp!=0: instruction=nop, fault_cause=2, fetch_fault=1, go DONE.
  - counter reaching TIMEOUT with no rvalid: fault_cause=3, fetch_fault=1, instruction=nop, rready=0, go DONE.
- DONE: IFU_done=1 for exactly one cycle, then go WAIT.
- WAIT: on pc_update, pc<=pc_next, fetch_fault=0, fault_cause=0, go REQ.
- Best-case latency: pc_update to IFU_done = 4 cycles (WAIT→REQ→ADDR→DATA→DONE) with arready and rvalid each asserted on first opportunity.
- pc_update outside WAIT: latch pc_next into pending register, set pending=1. On entering WAIT with pending=1, load it in the same cycle as if pc_update had arrived, then clear pending. A second early strobe overwrites the first.
- pc_update and pending simultaneous in WAIT: the live pc_update wins.
- rvalid while not in DATA: ignored (rready=0); no state change. This covers stale responses after reset.
- arready in same cycle as arvalid first rises: accepted, no extra cycle.
- instruction and pc stable from DONE until the next REQ; IDU may sample them any cycle in DONE/WAIT.
- Reset mid-transaction: arvalid/rready drop asynchronously. The outstanding transfer is abandoned, and fetch restarts at RESET_PC after reset deassertion.

Decomposition:
- Shared package ifu_pkg: state enum (REQ/ADDR/DATA/DONE/WAIT), fault_cause constants (FC_NONE/FC_MISALIGN/FC_BUSERR/FC_TIMEOUT), NOP_INSN=32'h0000_0013, RESP_OKAY=2'b00.
- Natural sub-module: ifu_timeout_cnt (clear/enable/expired, parameterised by TIMEOUT). Everything else stays inline.

Test Plan:
- Reset release, arready=1 and rvalid=1 rdata=32'h00100093 rresp=0 on first opportunity → araddr=32'h80000000, IFU_done pulse at cycle 3 after reset, instruction=32'h00100093, pc=32'h80000000.
- pc_update pc_next=32'h80000004, memory stalls arready 3 cycles and rvalid 2 cycles → arvalid held 4 cycles with araddr stable, single IFU_done, no fault.
- pc_update pc_next=32'h80000006 → no arvalid, IFU_done pulse, fetch_fault=1, fault_cause=1, instruction=32'h00000013.
- rvalid with rresp=2'b10 → fault_cause=2, instruction=nop. With TIMEOUT=8 and no rvalid → fault_cause=3 after 8 DATA cycles, rready drops.
- pc_update=32'h80000010 during DATA → current fetch completes, then immediate refetch at 32'h80000010 with no strobe in WAIT.
- rst asserted while arvalid=1 → arvalid=0 same cycle. Stray rvalid after release is ignored, and the first fetch is at 32'h80000000.
